// File: rtl/timer_alarm_sched.sv
// Alarm scheduler: N_CH deadline/period channels against one 48-bit timebase,
// serviced round-robin by a single shared comparator and reload adder.
module timer_alarm_sched #(
    parameter int N_CH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cs,
    input  logic            read,
    input  logic            write,
    input  logic [4:0]      addr,
    input  logic [31:0]     wr_data,
    output logic [31:0]     rd_data,
    input  logic [47:0]     time_in,
    output logic [N_CH-1:0] expired,
    output logic            irq
);

    localparam int SP_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [47:0]     deadline [N_CH];
    logic [31:0]     period   [N_CH];
    logic [N_CH-1:0] enable;
    logic [N_CH-1:0] periodic;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] irq_mask;
    logic [SP_W-1:0] sp;

    // Reads have no side effects, so the strobe carries no information.
    logic unused_read;
    assign unused_read = read;

    logic            wr_en;
    logic            wr_hit_p0;
    logic            fire_p0;
    logic [47:0]     reload_p0;
    logic [N_CH-1:0] set_p0;
    logic [N_CH-1:0] clr_p0;

    assign wr_en = cs && write;

    // Scan stage: evaluate channel sp; a bus write to that channel wins.
    assign wr_hit_p0 = wr_en && !addr[4] && (addr[3:2] == 2'(sp));
    assign fire_p0   = enable[sp] && (time_in >= deadline[sp]) && !wr_hit_p0;
    assign reload_p0 = deadline[sp] + {16'd0, period[sp]};

    always_comb begin
        set_p0 = '0;
        if (fire_p0)
            set_p0[sp] = 1'b1;
    end

    assign clr_p0 = (wr_en && addr == 5'b10001) ? wr_data[N_CH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                deadline[i] <= '0;
                period[i]   <= '0;
            end
            enable   <= '0;
            periodic <= '0;
            pending  <= '0;
            irq_mask <= '0;
            expired  <= '0;
            irq      <= 1'b0;
            sp       <= '0;
        end else begin
            sp      <= (int'(sp) == N_CH - 1) ? '0 : sp + 1'b1;
            expired <= set_p0;
            irq     <= |(pending & irq_mask);
            // A same-cycle set beats the W1C clear.
            pending <= (pending & ~clr_p0) | set_p0;

            if (fire_p0) begin
                if (periodic[sp] && period[sp] != 32'd0)
                    deadline[sp] <= reload_p0;
                else
                    enable[sp] <= 1'b0;
            end

            if (wr_en && !addr[4]) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (addr[3:2] == 2'(i)) begin
                        case (addr[1:0])
                            2'b00: deadline[i][31:0]  <= wr_data;
                            2'b01: deadline[i][47:32] <= wr_data[15:0];
                            2'b10: begin
                                enable[i]   <= wr_data[0];
                                periodic[i] <= wr_data[1];
                            end
                            default: period[i] <= wr_data;
                        endcase
                    end
                end
            end

            if (wr_en && addr == 5'b10010)
                irq_mask <= wr_data[N_CH-1:0];
        end
    end

    always_comb begin
        rd_data = '0;
        if (!addr[4]) begin
            for (int i = 0; i < N_CH; i++) begin
                if (addr[3:2] == 2'(i)) begin
                    case (addr[1:0])
                        2'b00:   rd_data = deadline[i][31:0];
                        2'b01:   rd_data = {16'd0, deadline[i][47:32]};
                        2'b10:   rd_data = {30'd0, periodic[i], enable[i]};
                        default: rd_data = period[i];
                    endcase
                end
            end
        end else begin
            case (addr[3:0])
                4'h0:    rd_data = 32'(pending);
                4'h2:    rd_data = 32'(irq_mask);
                4'h3:    rd_data = time_in[31:0];
                default: rd_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_alarm_sched.sv
// Directed bench for timer_alarm_sched: hand-computed expectations checked
// with immediate assertions along one linear stimulus sequence.
module tb_timer_alarm_sched;

    localparam int N_CH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            cs;
    logic            read;
    logic            write;
    logic [4:0]      addr;
    logic [31:0]     wr_data;
    logic [31:0]     rd_data;
    logic [47:0]     time_in;
    logic [N_CH-1:0] expired;
    logic            irq;

    int errors = 0;
    int checks = 0;

    // Channel the DUT will evaluate at the next rising edge.
    logic [1:0] sp_m;

    timer_alarm_sched #(.N_CH(N_CH)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .time_in (time_in),
        .expired (expired),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) sp_m <= reset ? 2'd0 : sp_m + 2'd1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cs      = 1'b1;
        write   = 1'b1;
        addr    = a;
        wr_data = d;
        step();
        cs      = 1'b0;
        write   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        read = 1'b1;
        #1;
        chk(tag, rd_data, exp);
        read = 1'b0;
    endtask

    task automatic rd_all(input string tag);
        logic [31:0] exp;
        for (int a = 0; a < 32; a++) begin
            exp = (a == 19) ? time_in[31:0] : 32'd0;
            rd_chk($sformatf("%s_rd%0d", tag, a), 5'(a), exp);
        end
    endtask

    initial begin
        int          nf;
        int          last;
        int          k;
        bit          gaps_ok;
        bit          seen;
        int          fires [8];
        logic [47:0] fire_t;

        reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
        addr = '0; wr_data = '0; time_in = '0;
        step(); step();
        reset = 1'b0;

        // Reset state
        chk("rst_irq", irq, 0);
        chk("rst_expired", expired, 0);
        rd_all("rst");

        // Catch-up: ch0 deadline 0, period 10, time held at 35 -> 4 fires
        time_in = 48'd35;
        wr(5'd0, 0); wr(5'd1, 0); wr(5'd3, 10); wr(5'd2, 3);
        nf = 0; last = 0; gaps_ok = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step();
            if (expired[0]) begin
                if (nf > 0 && i - last != 4) gaps_ok = 1'b0;
                last = i;
                nf++;
            end
        end
        chk("catchup_count", nf, 4);
        chk("catchup_consecutive", gaps_ok, 1);
        rd_chk("catchup_deadline", 5'd0, 40);
        wr(5'd2, 0); wr(5'd17, 32'hF);

        // Periodic: ch0 deadline 100, period 50, time ramps 90..220
        time_in = 48'd90;
        wr(5'd0, 100); wr(5'd3, 50); wr(5'd2, 3);
        nf = 0;
        for (int t = 90; t <= 220; t++) begin
            time_in = 48'(t);
            step();
            if (expired[0]) begin
                if (nf < 8) fires[nf] = t;
                nf++;
            end
        end
        chk("periodic_count", nf, 3);
        chk("periodic_fire100", (fires[0] >= 100 && fires[0] <= 103), 1);
        chk("periodic_fire150", (fires[1] >= 150 && fires[1] <= 153), 1);
        chk("periodic_fire200", (fires[2] >= 200 && fires[2] <= 203), 1);
        rd_chk("periodic_deadline", 5'd0, 250);
        chk("masked_irq", irq, 0);
        rd_chk("masked_pending", 5'd16, 1);
        wr(5'd2, 0); wr(5'd17, 32'hF);

        // One-shot: ch1 deadline 0x100, mask 0x2, time ramps from 0xF0
        time_in = 48'hF0;
        wr(5'd4, 32'h100); wr(5'd5, 0); wr(5'd18, 2); wr(5'd6, 1);
        seen = 1'b0; fire_t = '0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (expired[1]) begin
                seen = 1'b1;
                fire_t = time_in;
            end else begin
                time_in++;
            end
        end
        chk("oneshot_seen", seen, 1);
        chk("oneshot_latency", (fire_t >= 48'h100 && fire_t <= 48'h103), 1);
        chk("oneshot_expired", expired, 4'b0010);
        chk("oneshot_irq_lag", irq, 0);
        rd_chk("oneshot_pending", 5'd16, 2);
        time_in++;
        step();
        chk("oneshot_irq", irq, 1);
        chk("oneshot_pulse_width", expired, 0);
        nf = 0;
        for (int i = 0; i < 8; i++) begin
            time_in++;
            step();
            if (expired[1]) nf++;
        end
        chk("oneshot_once", nf, 0);
        rd_chk("oneshot_ctrl", 5'd6, 0);
        wr(5'd17, 2);
        chk("w1c_irq_lag", irq, 1);
        rd_chk("w1c_pending", 5'd16, 0);
        step();
        chk("w1c_irq_drop", irq, 0);

        // Bus write to ch3 in its scan cycle suppresses that cycle's fire
        time_in = 48'h200;
        wr(5'd12, 32'h300); wr(5'd13, 0); wr(5'd14, 1);
        for (int i = 0; i < 8 && sp_m != 2'd3; i++) step();
        time_in = 48'h310;
        wr(5'd12, 32'h300);
        chk("coll_no_pulse", expired, 0);
        rd_chk("coll_no_pending", 5'd16, 0);
        k = 0;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (expired[3] && k == 0) k = i;
        end
        chk("coll_next_visit", k, 4);
        rd_chk("coll_pending", 5'd16, 8);
        wr(5'd17, 32'hF);

        // Set and W1C of the same pending bit in one cycle
        wr(5'd6, 1);
        for (int i = 0; i < 8 && sp_m != 2'd1; i++) step();
        wr(5'd17, 2);
        chk("setclr_fire", expired, 4'b0010);
        rd_chk("setclr_pending", 5'd16, 2);
        wr(5'd17, 2);
        rd_chk("setclr_cleared", 5'd16, 0);

        // 48-bit carry on reload: ch2 0xFFFF_FFF0 + 0x20
        time_in = 48'h1_0000_0000;
        wr(5'd9, 32'hFFFF_0000);
        rd_chk("dl_hi_upper_zero", 5'd9, 0);
        wr(5'd8, 32'hFFFF_FFF0); wr(5'd9, 0); wr(5'd11, 32'h20); wr(5'd10, 3);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            if (expired[2]) seen = 1'b1;
        end
        chk("carry_seen", seen, 1);
        rd_chk("carry_dl_lo", 5'd8, 32'h10);
        rd_chk("carry_dl_hi", 5'd9, 32'h1);
        nf = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (expired[2]) nf++;
        end
        chk("carry_no_refire", nf, 0);
        wr(5'd10, 0);

        // Reset in the middle of a catch-up run
        wr(5'd0, 0); wr(5'd1, 0); wr(5'd3, 1); wr(5'd18, 32'hF); wr(5'd2, 3);
        nf = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (expired[0]) nf++;
        end
        chk("prerst_fires", nf, 3);
        chk("prerst_irq", irq, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_irq", irq, 0);
        chk("midrst_expired", expired, 0);
        rd_all("midrst");
        nf = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (expired != '0) nf++;
        end
        chk("postrst_quiet", nf, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_alarm_sched.md
Name: timer_alarm_sched

Overview:
- Slot-attached alarm scheduler that shares one 48-bit system timebase among N_CH independently programmable alarm channels.
- A single round-robin scan engine services all channels with one shared 48-bit comparator and adder, evaluating one channel per clock.
- Expired channels latch pending bits, pulse per-channel event lines and drive one maskable interrupt.
- Sits beside the timer core in the MMIO subsystem; its time_in is the timer core's 48-bit count.

Parameters:
- N_CH, 4, number of alarm channels; legal range 1..4, set by the addr[3:2] channel field.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cs  in  1  slot chip select
- read  in  1  slot read enable (unused; reads have no side effects)
- write  in  1  slot write enable
- addr  in  5  internal register address
- wr_data  in  32  write data
- rd_data  out  32  read data, combinational from addr
- time_in  in  48  current timebase value, monotonic non-decreasing
- expired  out  N_CH  one-clock pulse per channel on firing
- irq  out  1  registered; equals OR of (pending AND irq_mask)

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Register map, per channel, addr[4]=0, addr[3:2]=ch:
  - 00: deadline[31:0] (R/W)
  - 01: deadline[47:32] in bits 15:0 (R/W); upper read bits are 0
  - 10: ctrl. Bit0 = enable, bit1 = periodic (R/W).
  - 11: period[31:0] (R/W)
- Register map, global, addr[4]=1:
  - 10000: pending[N_CH-1:0] (R)
  - 10001: write-1-to-clear pending (W); reads 0
  - 10010: irq_mask (R/W)
  - 10011: time_in[31:0] (R)
  - Any other address reads 0.
- Channel numbers >= N_CH: writes are ignored and reads return 0.
- Write decode: a write takes effect when cs && write.
- Reset: every register, pending, irq_mask, expired, irq and the scan pointer go to 0.
- Scan pointer sp cycles 0,1,...,N_CH-1,0 and advances every clock, unconditionally.
- At cycle sp=i, the channel fires if enable[i]=1 and time_in >= deadline[i] (48-bit unsigned compare). Effects are registered at the clock edge:
  - pending[i] <= 1
  - expired[i] pulses high for exactly one cycle
  - If periodic[i]=1 and period[i]!=0: deadline[i] <= deadline[i] + period[i], zero-extended, mod 2^48, and enable stays 1.
  - Otherwise enable[i] <= 0 (one-shot).
- Detection latency: firing occurs within N_CH clocks of time_in reaching the deadline. irq asserts one clock after pending sets.
- Catch-up: a periodic channel far behind time_in fires once per scan visit until deadline > time_in. No firings are skipped or merged; each pulses expired.
- Collision, bus write vs scan: a bus write to any register of channel i in the same cycle that sp=i wins. That cycle's scan result for channel i is discarded: no pending set, no pulse, no reload.
- Collision, set vs clear: pending set and W1C clear of the same bit in the same cycle leaves the bit set.
- Masking: irq_mask changes take effect on irq the next clock. Masked pending bits still latch.
- Deadline wrap: no wrap-around handling; deadlines compare as plain unsigned values.
- Reset asserted mid-operation clears all state on that edge. Scanning restarts at channel 0.

Test Plan:
- Reset, then read all addresses -> all 0; irq=0 and expired=0.
- One-shot: ch1 deadline=0x0000_0000_0100, enable=1, mask=0x2; ramp time_in from 0xF0 -> at time_in=0x100:
  - expired[1] pulses exactly once within 4 clocks.
  - pending=0x2, then irq=1 on the following clock.
  - ch1 ctrl reads 0.
  - W1C 0x2 drops irq next clock.
- Periodic: ch0 deadline=100, period=50, periodic+enable, time_in ramps 1 per clock -> expired[0] pulses at times 100, 150, 200 (each within N_CH clocks). Deadline reads 250 after the third fire.
- 48-bit carry: ch2 deadline=0x0000_FFFF_FFF0, period=0x20, time_in=0x1_0000_0000 -> after the first fire, deadline reads low 0x0000_0010, high 0x0001.
- Collisions:
  - Write ch3 deadline in the cycle sp=3 with the ch3 condition true -> no pulse that cycle; fires on the next visit.
  - Simultaneous pending set and W1C of the same bit -> pending stays 1.
- Catch-up and reset: ch0 periodic, deadline=0, period=10, time_in held at 35 -> exactly 4 fires, on consecutive ch0 visits, then none. Assert reset mid-sequence -> all registers read 0 the next cycle.
